ninjin_ddr_resp: RTL and testbench
==================================

Name: ninjin_ddr_resp

Overview:
DDR-side responder for the ninjin buffer: services the ddr_we/ddr_re/ddr_addr/ddr_wdata request stream and returns ddr_rdata words after a fixed read latency. Backs a BWIDTH-wide word-addressed store of 2**MEMSIZE entries. Clears its store after reset before accepting traffic. Used as the bus-functional DDR endpoint in ninjin integration benches and as an on-chip scratch DDR substitute in small configurations.

Parameters:
BWIDTH, 128, data width of one DDR word (shared with ninjin package)
MEMSIZE, 12, address width; depth = 2**MEMSIZE words
RD_LAT, 2, cycles from accepted ddr_re to ddr_rvalid (legal 1..8)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
ddr_we  input  1  write request, one word per cycle
ddr_re  input  1  read request, one word per cycle
ddr_addr  input  MEMSIZE  word address for we/re
ddr_wdata  input  BWIDTH  write data
ddr_rdata  output  BWIDTH  read data, valid when ddr_rvalid
ddr_rvalid  output  1  read data strobe
ready  output  1  high once post-reset clear complete
err  output  1  sticky: request arrived while ready low

Behaviour:
- Reset (rst=1 at clk edge): state<=S_CLEAR, clear_addr<=0, ready<=0, err<=0, ddr_rvalid<=0, ddr_rdata<=0, read pipeline valids<=0. Reset mid-operation discards all in-flight reads; no ddr_rvalid after reset.
- FSM states: S_CLEAR, S_RUN.
- S_CLEAR: writes 0 to mem[clear_addr] each cycle, clear_addr++; at clear_addr==2**MEMSIZE-1 write and go S_RUN next cycle. Clear takes exactly 2**MEMSIZE cycles; ready rises the cycle S_RUN is entered.
- Requests (ddr_we or ddr_re) while state!=S_RUN: ignored, no write, no rvalid; err<=1 and stays 1 until rst.
- S_RUN write: ddr_we=1 at edge -> mem[ddr_addr]<=ddr_wdata, no response.
- S_RUN read: ddr_re=1 at edge T -> ddr_rvalid=1 and ddr_rdata=mem[addr] visible after edge T+RD_LAT, for one cycle. Back-to-back reads give back-to-back rvalid, order preserved, full throughput (one per cycle).
- ddr_rdata holds last value when ddr_rvalid=0.
- Simultaneous ddr_we and ddr_re in one cycle: both performed; read is read-first (returns data prior to that write), any address.
- Read after write: write at edge T, read same address at T+1 returns new data.
- Read data captured from array at accept edge (sync read); remaining RD_LAT-1 stages are a valid/data shift register.
- No backpressure: responder never stalls in S_RUN.
- Address wraps nowhere: full MEMSIZE range is valid; no out-of-range case.

Decomposition:
- ninjin package: BWIDTH, MEMSIZE, RD_LAT defaults; enum resp_state_t {S_CLEAR, S_RUN}.
- One sub-module: ninjin_ddr_resp_pipe — parameterised RD_LAT-1 stage valid+data delay line with synchronous active-high clear; top holds FSM, clear counter, array, err.

Test Plan:
- Reset then idle: ready=0 for exactly 4096 cycles (MEMSIZE=12), ready=1 at cycle 4096; read addr 100 -> rvalid 2 cycles later, rdata=0.
- ddr_re pulsed during clear at cycle 10 -> err=1 remains 1, no rvalid ever; after rst err=0.
- Write addr i data i*3 for i=0..15, then 16 back-to-back reads addr 0..15 -> 16 consecutive rvalid cycles starting 2 cycles after first read, rdata=0,3,...,45 in order.
- Same cycle we=1,re=1 addr 7 (mem[7]=21, wdata=99) -> rdata=21; next read addr 7 -> 99.
- Write addr 4095 data all-ones, read 4095 at next cycle -> all-ones; read addr 0 -> previous value.
- Issue 2 reads, assert rst the following cycle -> no rvalid within 3 cycles, rdata=0, ready=0, clear restarts.

Source files
------------

// File: rtl/ninjin_ddr_resp_pkg.sv
// Shared defaults and state encoding for the ninjin DDR-side responder.
package ninjin_ddr_resp_pkg;

    localparam int DDR_BWIDTH  = 128;
    localparam int DDR_MEMSIZE = 12;
    localparam int DDR_RD_LAT  = 2;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } resp_state_t;

endpackage

// File: rtl/ninjin_ddr_resp_pipe.sv
// Valid/data delay line for read responses; data only advances alongside a valid
// so the last delivered word stays parked at the end of the line.
module ninjin_ddr_resp_pipe #(
    parameter int W      = 128,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         vld_in,
    input  logic [W-1:0] dat_in,
    output logic         vld_out,
    output logic [W-1:0] dat_out
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_ctl;
            assign unused_ctl = ^{clk, clr};
            assign vld_out    = vld_in;
            assign dat_out    = dat_in;
        end else begin : g_stages
            logic [STAGES-1:0]        vld_pipe;
            logic [STAGES-1:0][W-1:0] dat_pipe;

            always_ff @(posedge clk) begin
                if (clr) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    vld_pipe[0] <= vld_in;
                    if (vld_in) dat_pipe[0] <= dat_in;
                    for (int i = 1; i < STAGES; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
                    end
                end
            end

            assign vld_out = vld_pipe[STAGES-1];
            assign dat_out = dat_pipe[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ninjin_ddr_resp.sv
// DDR endpoint for the ninjin buffer: zero-fills its store after reset, then
// serves one write and/or one read per cycle with fixed read latency.
module ninjin_ddr_resp
    import ninjin_ddr_resp_pkg::*;
#(
    parameter int BWIDTH  = DDR_BWIDTH,
    parameter int MEMSIZE = DDR_MEMSIZE,
    parameter int RD_LAT  = DDR_RD_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ddr_we,
    input  logic               ddr_re,
    input  logic [MEMSIZE-1:0] ddr_addr,
    input  logic [BWIDTH-1:0]  ddr_wdata,
    output logic [BWIDTH-1:0]  ddr_rdata,
    output logic               ddr_rvalid,
    output logic               ready,
    output logic               err
);

    localparam int DEPTH = 1 << MEMSIZE;

    resp_state_t        state;
    logic [MEMSIZE-1:0] clear_addr;
    logic [BWIDTH-1:0]  mem [DEPTH];

    logic               run;
    logic               rd_acc;
    logic               rd_vld0;
    logic [BWIDTH-1:0]  rd_dat0;
    logic               pipe_vld;
    logic [BWIDTH-1:0]  pipe_dat;

    assign run    = (state == S_RUN);
    assign rd_acc = run && ddr_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            clear_addr <= '0;
            ready      <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (!run && (ddr_we || ddr_re)) err <= 1'b1;
            if (!run) begin
                clear_addr <= clear_addr + MEMSIZE'(1);
                if (&clear_addr) begin
                    state <= S_RUN;
                    ready <= 1'b1;
                end
            end
        end
    end

    // Single write port shared by the clear sweep and user writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run)
                mem[clear_addr] <= '0;
            else if (ddr_we)
                mem[ddr_addr] <= ddr_wdata;
        end
    end

    // Sync read sees the array before any same-edge write: read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld0 <= 1'b0;
            rd_dat0 <= '0;
        end else begin
            rd_vld0 <= rd_acc;
            if (rd_acc) rd_dat0 <= mem[ddr_addr];
        end
    end

    ninjin_ddr_resp_pipe #(
        .W      (BWIDTH),
        .STAGES (RD_LAT - 1)
    ) u_pipe (
        .clk     (clk),
        .clr     (rst),
        .vld_in  (rd_vld0),
        .dat_in  (rd_dat0),
        .vld_out (pipe_vld),
        .dat_out (pipe_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ddr_rvalid <= 1'b0;
            ddr_rdata  <= '0;
        end else begin
            ddr_rvalid <= pipe_vld;
            if (pipe_vld) ddr_rdata <= pipe_dat;
        end
    end

endmodule

// File: tb/tb_ninjin_ddr_resp.sv
// Randomized bench for ninjin_ddr_resp against a cycle-counting reference model.
module tb_ninjin_ddr_resp;
    import ninjin_ddr_resp_pkg::*;

    localparam int BW    = DDR_BWIDTH;
    localparam int MS    = DDR_MEMSIZE;
    localparam int LAT   = DDR_RD_LAT;
    localparam int DEPTH = 1 << MS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ddr_we = 1'b0, ddr_re = 1'b0;
    logic [MS-1:0] ddr_addr = '0;
    logic [BW-1:0] ddr_wdata = '0;
    logic [BW-1:0] ddr_rdata;
    logic          ddr_rvalid, ready, err;

    ninjin_ddr_resp dut (
        .clk(clk), .rst(rst), .ddr_we(ddr_we), .ddr_re(ddr_re),
        .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata), .ddr_rdata(ddr_rdata),
        .ddr_rvalid(ddr_rvalid), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [BW-1:0] d;
    } exp_t;

    // Reference model: array contents, pending responses, cycle count.
    logic [BW-1:0] model [DEPTH];
    exp_t          pend [$];
    int            cyc = 0;
    int            clr_cnt = 0;
    logic          m_ready = 1'b0, m_err = 1'b0;
    logic [BW-1:0] m_last = '0;
    int            n_chk = 0, n_err = 0;
    int            rv_seen = 0;

    task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive, let the edge happen, advance the model, check outputs.
    task automatic tick(input logic we, input logic re, input logic [MS-1:0] a, input logic [BW-1:0] wd);
        exp_t e;
        logic          x_vld;
        logic [BW-1:0] x_dat;
        ddr_we = we; ddr_re = re; ddr_addr = a; ddr_wdata = wd;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pend.delete();
            m_ready = 1'b0; m_err = 1'b0; clr_cnt = 0; m_last = '0;
        end else if (!m_ready) begin
            if (we || re) m_err = 1'b1;
            clr_cnt++;
            if (clr_cnt == DEPTH) begin
                m_ready = 1'b1;
                foreach (model[i]) model[i] = '0;
            end
        end else begin
            if (re) begin
                e.due = cyc + LAT;
                e.d   = model[a];
                pend.push_back(e);
            end
            if (we) model[a] = wd;
        end
        @(negedge clk);
        x_vld = 1'b0;
        x_dat = m_last;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            x_vld  = 1'b1;
            x_dat  = pend[0].d;
            m_last = pend[0].d;
            void'(pend.pop_front());
        end
        if (ddr_rvalid) rv_seen++;
        chk("ready", BW'(ready), BW'(m_ready));
        chk("err", BW'(err), BW'(m_err));
        chk("rvalid", BW'(ddr_rvalid), BW'(x_vld));
        chk("rdata", ddr_rdata, x_dat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [BW-1:0] ones;
        int            ready_lo;
        ones = '1;

        // Reset then idle: ready must stay low for exactly DEPTH cycles.
        do_reset();
        ready_lo = 0;
        while (!ready && ready_lo < DEPTH + 10) begin
            tick(1'b0, 1'b0, '0, '0);
            if (!ready) ready_lo++;
        end
        chk("ready_low_cycles", BW'(ready_lo), BW'(DEPTH - 1));
        chk("ready_after_clear", BW'(ready), BW'(1));
        tick(1'b0, 1'b1, MS'(100), '0);
        idle(LAT + 1);

        // Request during clear sets sticky err and never answers.
        do_reset();
        idle(10);
        rv_seen = 0;
        tick(1'b0, 1'b1, MS'(5), '0);
        idle(DEPTH + 5);
        chk("err_sticky", BW'(err), BW'(1));
        chk("no_rvalid_clear", BW'(rv_seen), BW'(0));
        do_reset();
        chk("err_cleared", BW'(err), BW'(0));
        idle(DEPTH);

        // Sequential writes then back-to-back reads.
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, MS'(i), BW'(i * 3));
        rv_seen = 0;
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, MS'(i), '0);
        idle(LAT + 1);
        chk("b2b_count", BW'(rv_seen), BW'(16));

        // Read-first on simultaneous write/read, then read-after-write.
        tick(1'b1, 1'b1, MS'(7), BW'(99));
        tick(1'b0, 1'b1, MS'(7), '0);
        idle(LAT + 1);

        // Top address boundary.
        tick(1'b1, 1'b0, MS'(DEPTH - 1), ones);
        tick(1'b0, 1'b1, MS'(DEPTH - 1), '0);
        tick(1'b0, 1'b1, MS'(0), '0);
        idle(LAT + 1);

        // Random traffic over a small address window plus the top word.
        for (int i = 0; i < 400; i++) begin
            logic [MS-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? MS'(DEPTH - 1) : MS'($urandom_range(0, 31));
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, rnd_word());
        end
        idle(LAT + 1);

        // Reset with reads in flight: nothing may come out afterwards.
        tick(1'b0, 1'b1, MS'(3), '0);
        tick(1'b0, 1'b1, MS'(4), '0);
        rst = 1'b1;
        rv_seen = 0;
        tick(1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        idle(3);
        chk("rst_flush_rvalid", BW'(rv_seen), BW'(0));
        chk("rst_rdata_zero", ddr_rdata, '0);
        chk("rst_ready_low", BW'(ready), BW'(0));
        idle(50);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
